// File: rtl/usb_wire_access_sched.sv
// -----------------------------------------------------------------------------
// usb_wire_access_sched
//
// Arbitrates ownership of the USB wire between the SIE packet transmitter and
// the line-state signaller (reset/resume/keep-alive), and tracks the receive
// side so that no transmitter is granted while the wire is busy or before the
// bus turnaround gap has elapsed. After a packet that expects a response, it
// arms the wire reader's no-activity timeout and reports a response timeout.
//
// Parameters
//   FS_OVER_SAMPLE_RATE : clk cycles per full-speed USB bit
//   LS_OVER_SAMPLE_RATE : clk cycles per low-speed USB bit
//   TURNAROUND_BITS     : idle bit periods required before any TX grant
//
// Ports
//   clk                     : clock, rising edge
//   rst                     : asynchronous reset, active-low
//   fullSpeedRate           : 1 = full-speed bit timing, 0 = low-speed
//   sieTxReq / sieTxGnt     : SIE transmitter level request / grant
//   sieTxDone               : 1-cycle pulse, end of SIE packet
//   expectResp              : sampled with sieTxDone, response expected
//   ctrlTxReq / ctrlTxGnt   : line-state signaller level request / grant
//   ctrlTxDone              : 1-cycle pulse, end of signalling
//   RxWireActive            : receive activity from the wire reader
//   noActivityTimeOut       : timeout pulse from the wire reader
//   TxWireActiveDrive       : 1 while a transmitter owns the wire
//   noActivityTimeOutEnable : enables the reader's timeout counter
//   respTimeOut             : 1-cycle pulse, expected response never started
// -----------------------------------------------------------------------------
module usb_wire_access_sched #(
    parameter int FS_OVER_SAMPLE_RATE = 4,
    parameter int LS_OVER_SAMPLE_RATE = 32,
    parameter int TURNAROUND_BITS     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic fullSpeedRate,
    input  logic sieTxReq,
    output logic sieTxGnt,
    input  logic sieTxDone,
    input  logic expectResp,
    input  logic ctrlTxReq,
    output logic ctrlTxGnt,
    input  logic ctrlTxDone,
    input  logic RxWireActive,
    input  logic noActivityTimeOut,
    output logic TxWireActiveDrive,
    output logic noActivityTimeOutEnable,
    output logic respTimeOut
);

    localparam int unsigned FS_GAP = TURNAROUND_BITS * FS_OVER_SAMPLE_RATE;
    localparam int unsigned LS_GAP = TURNAROUND_BITS * LS_OVER_SAMPLE_RATE;

    typedef enum logic [2:0] {
        IDLE,
        SIE_TX,
        CTRL_TX,
        RESP_WAIT,
        RX_BUSY
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] gap_cnt;
    logic       gap_ok;
    logic       last_gnt_ctrl;   // 1 = ctrl won the last grant, so sie is favoured next
    logic       timeout_hit;
    logic       tx_state;

    assign tx_state = (state == SIE_TX) || (state == CTRL_TX);

    // The rate select is read combinationally so a change takes effect at the
    // very next gap evaluation without disturbing the state machine.
    always_comb begin
        if (fullSpeedRate) begin
            gap_ok = (32'(gap_cnt) >= FS_GAP);
        end else begin
            gap_ok = (32'(gap_cnt) >= LS_GAP);
        end
    end

    // Idle-gap counter: cleared by any wire activity (ours or the far end's),
    // saturating so a long-idle bus always satisfies the turnaround.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap_cnt <= 8'hff;
        end else if (RxWireActive || tx_state) begin
            gap_cnt <= 8'h00;
        end else if (gap_cnt != 8'hff) begin
            gap_cnt <= gap_cnt + 8'h01;
        end
    end

    always_comb begin
        next_state  = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (RxWireActive) begin
                    next_state = RX_BUSY;
                end else if (gap_ok) begin
                    if (sieTxReq && ctrlTxReq) begin
                        next_state = last_gnt_ctrl ? SIE_TX : CTRL_TX;
                    end else if (sieTxReq) begin
                        next_state = SIE_TX;
                    end else if (ctrlTxReq) begin
                        next_state = CTRL_TX;
                    end
                end
            end
            // A grant is held until its own done pulse; request drops and the
            // other requester's done pulse are deliberately ignored.
            SIE_TX: begin
                if (sieTxDone) begin
                    next_state = expectResp ? RESP_WAIT : IDLE;
                end
            end
            CTRL_TX: begin
                if (ctrlTxDone) begin
                    next_state = IDLE;
                end
            end
            // Receive activity wins over a coincident timeout: the response
            // did start, so no timeout is reported.
            RESP_WAIT: begin
                if (RxWireActive) begin
                    next_state = RX_BUSY;
                end else if (noActivityTimeOut) begin
                    next_state  = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            RX_BUSY: begin
                if (!RxWireActive) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt_ctrl <= 1'b0;
        end else if (state == IDLE) begin
            if (next_state == SIE_TX) begin
                last_gnt_ctrl <= 1'b0;
            end else if (next_state == CTRL_TX) begin
                last_gnt_ctrl <= 1'b1;
            end
        end
    end

    // Outputs are registered from the next state so they line up exactly with
    // the state register and drop asynchronously on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sieTxGnt                <= 1'b0;
            ctrlTxGnt               <= 1'b0;
            TxWireActiveDrive       <= 1'b0;
            noActivityTimeOutEnable <= 1'b0;
            respTimeOut             <= 1'b0;
        end else begin
            sieTxGnt                <= (next_state == SIE_TX);
            ctrlTxGnt               <= (next_state == CTRL_TX);
            TxWireActiveDrive       <= (next_state == SIE_TX) || (next_state == CTRL_TX);
            noActivityTimeOutEnable <= (next_state == RESP_WAIT);
            respTimeOut             <= timeout_hit;
        end
    end

endmodule

// File: tb/tb_usb_wire_access_sched.sv
// -----------------------------------------------------------------------------
// tb_usb_wire_access_sched
//
// Table-driven bench for usb_wire_access_sched with default parameters
// (full-speed gap 8 cycles, low-speed gap 64 cycles). Each step drives one set
// of inputs, queues the expected outputs, clocks once and compares.
// Output vector order: {sieTxGnt, ctrlTxGnt, TxWireActiveDrive,
//                       noActivityTimeOutEnable, respTimeOut}
// -----------------------------------------------------------------------------
module tb_usb_wire_access_sched;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic fullSpeedRate = 1'b1;
    logic sieTxReq = 1'b0;
    logic sieTxGnt;
    logic sieTxDone = 1'b0;
    logic expectResp = 1'b0;
    logic ctrlTxReq = 1'b0;
    logic ctrlTxGnt;
    logic ctrlTxDone = 1'b0;
    logic RxWireActive = 1'b0;
    logic noActivityTimeOut = 1'b0;
    logic TxWireActiveDrive;
    logic noActivityTimeOutEnable;
    logic respTimeOut;

    usb_wire_access_sched dut (
        .clk                     (clk),
        .rst                     (rst),
        .fullSpeedRate           (fullSpeedRate),
        .sieTxReq                (sieTxReq),
        .sieTxGnt                (sieTxGnt),
        .sieTxDone               (sieTxDone),
        .expectResp              (expectResp),
        .ctrlTxReq               (ctrlTxReq),
        .ctrlTxGnt               (ctrlTxGnt),
        .ctrlTxDone              (ctrlTxDone),
        .RxWireActive            (RxWireActive),
        .noActivityTimeOut       (noActivityTimeOut),
        .TxWireActiveDrive       (TxWireActiveDrive),
        .noActivityTimeOutEnable (noActivityTimeOutEnable),
        .respTimeOut             (respTimeOut)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] Z = 5'b00000;  // nothing asserted
    localparam logic [4:0] S = 5'b10100;  // SIE granted, wire driven
    localparam logic [4:0] C = 5'b01100;  // ctrl granted, wire driven
    localparam logic [4:0] W = 5'b00010;  // waiting for response
    localparam logic [4:0] T = 5'b00001;  // response timeout pulse

    typedef struct {
        string      name;
        logic       rx, fs, sreq, creq, sdone, cdone, eresp, nato;
        logic [4:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [4:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(string n, logic rx, logic fs, logic sreq, logic creq,
                                logic sdone, logic cdone, logic eresp, logic nato,
                                logic [4:0] e);
        vec_t v;
        v.name = n; v.rx = rx; v.fs = fs; v.sreq = sreq; v.creq = creq;
        v.sdone = sdone; v.cdone = cdone; v.eresp = eresp; v.nato = nato; v.exp = e;
        return v;
    endfunction

    function automatic logic [4:0] outs();
        return {sieTxGnt, ctrlTxGnt, TxWireActiveDrive, noActivityTimeOutEnable, respTimeOut};
    endfunction

    task automatic check_front();
        sb_t s;
        logic [4:0] got;
        if (sbq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_empty: got no entry, want one");
        end else begin
            s   = sbq.pop_front();
            got = outs();
            n_cmp++;
            if (got !== s.exp) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", s.name, got, s.exp);
            end
        end
    endtask

    // Compare outputs right now (used around asynchronous reset).
    task automatic chk_now(string n, logic [4:0] e);
        sb_t s;
        s.name = n; s.exp = e;
        sbq.push_back(s);
        check_front();
    endtask

    task automatic apply(vec_t v);
        sb_t s;
        RxWireActive      = v.rx;
        fullSpeedRate     = v.fs;
        sieTxReq          = v.sreq;
        ctrlTxReq         = v.creq;
        sieTxDone         = v.sdone;
        ctrlTxDone        = v.cdone;
        expectResp        = v.eresp;
        noActivityTimeOut = v.nato;
        s.name = v.name; s.exp = v.exp;
        sbq.push_back(s);
        @(posedge clk);
        #1;
        check_front();
    endtask

    task automatic st(string n, logic rx, logic fs, logic sreq, logic creq,
                      logic sdone, logic cdone, logic eresp, logic nato, logic [4:0] e);
        apply(mk(n, rx, fs, sreq, creq, sdone, cdone, eresp, nato, e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            name            rx fs sq cq sd cd er na exp
        vecs.push_back(mk("both_req_ctrl", 0, 1, 1, 1, 0, 0, 0, 0, C));
        vecs.push_back(mk("ctrl_hold",     0, 1, 1, 1, 0, 0, 0, 0, C));
        vecs.push_back(mk("ctrl_ign_sdone",0, 1, 1, 0, 1, 0, 0, 0, C));
        vecs.push_back(mk("ctrl_done",     0, 1, 1, 1, 0, 1, 0, 0, Z));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk("rr_gap_wait", 0, 1, 1, 1, 0, 0, 0, 0, Z));
        vecs.push_back(mk("rr_sie_next",   0, 1, 1, 1, 0, 0, 0, 0, S));
        vecs.push_back(mk("sie_hold_drop", 0, 1, 0, 0, 0, 1, 0, 0, S));
        vecs.push_back(mk("sie_done_resp", 0, 1, 0, 0, 1, 0, 1, 0, W));
        vecs.push_back(mk("resp_wait",     0, 1, 0, 0, 0, 0, 0, 0, W));
        vecs.push_back(mk("resp_timeout",  0, 1, 0, 0, 0, 0, 0, 1, T));
        vecs.push_back(mk("timeout_1cyc",  0, 1, 0, 0, 0, 0, 0, 0, Z));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk("gap_wait2",   0, 1, 1, 0, 0, 0, 0, 0, Z));
        vecs.push_back(mk("sie_grant2",    0, 1, 1, 0, 0, 0, 0, 0, S));
        vecs.push_back(mk("sie_done_resp2",0, 1, 0, 0, 1, 0, 1, 0, W));
        vecs.push_back(mk("rx_beats_to",   1, 1, 0, 0, 0, 0, 0, 1, Z));
        vecs.push_back(mk("rx_busy_nognt", 1, 1, 1, 0, 0, 0, 0, 0, Z));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk("post_rx_gap", 0, 1, 1, 0, 0, 0, 0, 0, Z));
        vecs.push_back(mk("post_rx_grant", 0, 1, 1, 0, 0, 0, 0, 0, S));
        vecs.push_back(mk("sie_done_idle", 0, 1, 0, 0, 1, 0, 0, 0, Z));

        repeat (2) @(posedge clk);
        #1;
        chk_now("reset_outputs", Z);
        rst = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Rate switch mid-gap: low-speed gap not yet met, switching to
        // full-speed grants at the next evaluation.
        for (int i = 0; i < 20; i++) st("ls_gap_partial", 0, 0, 1, 0, 0, 0, 0, 0, Z);
        st("fs_switch_grant", 0, 1, 1, 0, 0, 0, 0, 0, S);
        st("sie_done_a",      0, 1, 0, 0, 1, 0, 0, 0, Z);

        // Full low-speed gap boundary: 64 idle cycles needed.
        for (int i = 0; i < 64; i++) st("ls_gap_wait", 0, 0, 1, 0, 0, 0, 0, 0, Z);
        st("ls_grant",        0, 0, 1, 0, 0, 0, 0, 0, S);
        st("sie_done_b",      0, 0, 0, 0, 1, 0, 0, 0, Z);

        // Reset in the middle of a ctrl transmission.
        for (int i = 0; i < 8; i++) st("ctrl_gap_wait", 0, 1, 0, 1, 0, 0, 0, 0, Z);
        st("ctrl_grant",      0, 1, 0, 1, 0, 0, 0, 0, C);
        st("ctrl_grant_hold", 0, 1, 0, 1, 0, 0, 0, 0, C);
        #2;
        rst = 1'b0;
        #1;
        chk_now("async_reset_drop", Z);
        @(posedge clk);
        #1;
        chk_now("reset_held", Z);
        rst = 1'b1;
        st("first_after_rst", 0, 1, 1, 0, 0, 0, 0, 0, S);
        st("sie_done_c",      0, 1, 0, 0, 1, 0, 0, 0, Z);

        // Receive activity in IDLE blocks a grant even with gap long satisfied.
        rst = 1'b0;
        #1;
        rst = 1'b1;
        st("idle_rx_nognt",   1, 1, 1, 0, 0, 0, 0, 0, Z);
        st("rx_busy_hold",    1, 1, 1, 0, 0, 0, 0, 0, Z);
        st("rx_end_idle",     0, 1, 0, 0, 0, 0, 0, 0, Z);
        st("stray_done_idle", 0, 1, 0, 0, 1, 1, 1, 0, Z);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
